// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multicycle instruction-fetch controller.
// Owns the PC, keeps at most one instruction-memory request outstanding
// (req/gnt/rvalid), and hands each fetched word to decode over a
// valid/ready handshake. Redirects from branch/jump control replace the PC
// and squash any stale in-flight response or held instruction.
//
// Handshake semantics (all sampled on the rising clock edge):
//   imem_req/imem_gnt : a request transfers in a cycle where both are high;
//                       imem_addr is held stable until then unless a redirect
//                       replaces the PC.
//   imem_rvalid       : response for the single outstanding request; it is
//                       only looked at in S_WAIT.
//   if_valid/if_ready : an instruction transfers in a cycle where both are
//                       high; if_instr/if_pc are stable while if_valid is
//                       high; if_ready without if_valid has no effect.
//
// Optional build macro: PC_ALIGN_CHK_EN
//   defined   -> misaligned redirect targets (redirect_pc[1:0] != 0) are
//                refused and reported on misalign_trap/misalign_addr.
//   undefined -> those ports do not exist; the target's low two bits are
//                cleared before it is loaded into the PC.
//
// The FSM state register state_q is exposed for checker binding.
module fetch_sequencer #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [XLEN-1:0] PC_INC     = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  logic [1:0]      state_q,    state_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            kill_q,     kill_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q,    if_pc_d;

  // Redirect qualification: whether the redirect is honoured and where it goes.
  logic            redir_take;
  logic [XLEN-1:0] redir_target;

`ifdef PC_ALIGN_CHK_EN
  logic            misaligned;
  logic            trap_q,  trap_d;
  logic [XLEN-1:0] maddr_q, maddr_d;

  // A misaligned target is refused outright; aligned targets pass untouched.
  always_comb begin
    misaligned   = redirect && (redirect_pc[1:0] != 2'b00);
    redir_take   = redirect && !misaligned;
    redir_target = redirect_pc;
  end

  // Trap pulses the cycle after a refused redirect; the address is kept.
  always_comb begin
    trap_d  = misaligned;
    maddr_d = maddr_q;
    if (misaligned) begin
      maddr_d = redirect_pc;
    end
  end

  // Trap reporting registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      trap_q  <= trap_d;
      maddr_q <= maddr_d;
    end
  end

  assign misalign_trap = trap_q;
  assign misalign_addr = maddr_q;
`else
  // Without alignment checking the target is forced onto a word boundary.
  always_comb begin
    redir_take   = redirect;
    redir_target = redirect_pc & ALIGN_MASK;
  end
`endif

  // Fetch FSM next-state logic; a redirect beats the sequential increment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          fetch_pc_d = pc_q;
          state_d    = S_WAIT;
          if (redir_take) begin
            // The granted request targets the old PC: squash its response.
            pc_d   = redir_target;
            kill_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end else if (redir_take) begin
          pc_d = redir_target;
        end
      end

      S_WAIT: begin
        if (redir_take) begin
          pc_d = redir_target;
          if (imem_rvalid) begin
            // Response arrives alongside the redirect: drop it right here.
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = fetch_pc_q;
            if_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redir_take) begin
          // Either consumed this cycle or flushed; both leave for the target.
          pc_d       = redir_target;
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end

      default: begin
        state_d    = S_REQ;
        if_valid_d = 1'b0;
        kill_d     = 1'b0;
      end
    endcase
  end

  // Fetch FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // Request is suppressed while reset is held even though state reads S_REQ.
  assign imem_req  = rst_n && (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed cycle-exact stimulus, with a
// scoreboard of expected grant addresses and expected presented instructions.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef PC_ALIGN_CHK_EN
  logic        misalign_trap;
  logic [31:0] misalign_addr;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_if_q[$];

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc)
`ifdef PC_ALIGN_CHK_EN
    ,
    .misalign_trap (misalign_trap),
    .misalign_addr (misalign_addr)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every granted address and every newly presented instruction
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_gnt) begin
        if (exp_addr_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL grant_unexpected: got grant at 0x%0h expected none", imem_addr);
        end else begin
          chk("grant_addr", {32'h0, imem_addr}, {32'h0, exp_addr_q.pop_front()});
        end
      end
      if (if_valid && !prev_valid) begin
        if (exp_if_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL if_unexpected: got pc 0x%0h instr 0x%0h expected none", if_pc, if_instr);
        end else begin
          chk("if_pc_instr", {if_pc, if_instr}, exp_if_q.pop_front());
        end
      end
    end
    prev_valid = if_valid;
  end

  // Driver: one fetch up to the point where decode sees it (S_HOLD)
  task automatic to_hold(input logic [31:0] addr, input int gdly, input int rdly,
                         input logic [31:0] instr);
    for (int i = 0; i < gdly; i++) begin
      chk("req_held", {63'h0, imem_req}, 64'h1);
      chk("addr_stable", {32'h0, imem_addr}, {32'h0, addr});
      tick();
    end
    exp_addr_q.push_back(addr);
    exp_if_q.push_back({addr, instr});
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 1; i < rdly; i++) begin
      chk("wait_no_req", {63'h0, imem_req}, 64'h0);
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = instr;
    tick();
    imem_rvalid = 1'b0;
    chk("valid_after_rvalid", {63'h0, if_valid}, 64'h1);
  endtask

  // Driver: full fetch including decode acceptance
  task automatic fetch(input logic [31:0] addr, input int gdly, input int rdly,
                       input logic [31:0] instr);
    to_hold(addr, gdly, rdly, instr);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("valid_drop", {63'h0, if_valid}, 64'h0);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_req",      {63'h0, imem_req}, 64'h0);
    chk("rst_valid",    {63'h0, if_valid}, 64'h0);
    chk("rst_instr",    {32'h0, if_instr}, 64'h0);
    chk("rst_if_pc",    {32'h0, if_pc},    64'h0);
    chk("rst_addr",     {32'h0, imem_addr}, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", {63'h0, imem_req}, 64'h1);

    // Sequential fetch 0x0, 0x4, 0x8, 0xC
    fetch(32'h0000_0000, 0, 1, 32'h0000_0013);
    fetch(32'h0000_0004, 0, 1, 32'h0010_0093);
    fetch(32'h0000_0008, 0, 1, 32'h0020_0113);
    fetch(32'h0000_000C, 0, 1, 32'h0030_0193);

    // Grant delayed 3 cycles at 0x10
    chk("addr_0x10", {32'h0, imem_addr}, 64'h10);
    fetch(32'h0000_0010, 3, 1, 32'h0040_0213);
    chk("addr_0x14", {32'h0, imem_addr}, 64'h14);

    // Redirect in S_WAIT, stale response arrives two cycles later
    exp_addr_q.push_back(32'h0000_0014);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    do_redirect(32'h0000_0100);
    chk("kill_valid_a", {63'h0, if_valid}, 64'h0);
    tick();
    chk("kill_valid_b", {63'h0, if_valid}, 64'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("kill_valid_c", {63'h0, if_valid}, 64'h0);
    chk("kill_req",     {63'h0, imem_req}, 64'h1);
    chk("kill_addr",    {32'h0, imem_addr}, 64'h100);

    // Consecutive redirects in S_REQ: last wins
    do_redirect(32'h0000_0200);
    chk("redir1_addr", {32'h0, imem_addr}, 64'h200);
    do_redirect(32'h0000_0020);
    chk("redir2_addr", {32'h0, imem_addr}, 64'h20);

    // Flush of a held instruction
    to_hold(32'h0000_0020, 0, 1, 32'h0200_0293);
    chk("hold_pc",    {32'h0, if_pc},    64'h20);
    chk("hold_instr", {32'h0, if_instr}, 64'h0200_0293);
    do_redirect(32'h0000_0040);
    chk("flush_valid", {63'h0, if_valid}, 64'h0);
    chk("flush_req",   {63'h0, imem_req}, 64'h1);
    chk("flush_addr",  {32'h0, imem_addr}, 64'h40);

    // Redirect coincident with decode acceptance
    to_hold(32'h0000_0040, 1, 1, 32'h0400_0313);
    if_ready = 1'b1;
    do_redirect(32'h0000_0030);
    if_ready = 1'b0;
    chk("acc_redir_valid", {63'h0, if_valid}, 64'h0);
    chk("acc_redir_addr",  {32'h0, imem_addr}, 64'h30);

    // Redirect coincident with grant at 0x30
    exp_addr_q.push_back(32'h0000_0030);
    imem_gnt = 1'b1;
    do_redirect(32'h0000_0080);
    imem_gnt = 1'b0;
    chk("gnt_redir_req", {63'h0, imem_req}, 64'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0300_0393;
    tick();
    imem_rvalid = 1'b0;
    chk("gnt_redir_valid", {63'h0, if_valid}, 64'h0);
    chk("gnt_redir_addr",  {32'h0, imem_addr}, 64'h80);

    // Stray rvalid and if_ready in S_REQ are ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0BAD;
    if_ready    = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    if_ready    = 1'b0;
    chk("stray_valid", {63'h0, if_valid}, 64'h0);
    chk("stray_req",   {63'h0, imem_req}, 64'h1);
    chk("stray_addr",  {32'h0, imem_addr}, 64'h80);
    fetch(32'h0000_0080, 0, 2, 32'h0080_0413);

    // Misaligned redirect target
    do_redirect(32'h0000_0102);
`ifdef PC_ALIGN_CHK_EN
    chk("trap_pulse",  {63'h0, misalign_trap}, 64'h1);
    chk("trap_addr",   {32'h0, misalign_addr}, 64'h102);
    chk("trap_pc",     {32'h0, imem_addr},     64'h84);
    tick();
    chk("trap_clear",  {63'h0, misalign_trap}, 64'h0);
    chk("trap_hold",   {32'h0, misalign_addr}, 64'h102);
    fetch(32'h0000_0084, 0, 1, 32'h0090_0493);
`else
    chk("align_force", {32'h0, imem_addr}, 64'h100);
    fetch(32'h0000_0100, 0, 1, 32'h0090_0493);
`endif

    // PC wraps silently at the top of the address space
    do_redirect(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 0, 1, 32'h00A0_0513);
    chk("wrap_addr", {32'h0, imem_addr}, 64'h0);

    // Reset mid-operation; late response after release is ignored
    exp_addr_q.push_back(32'h0000_0000);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req",   {63'h0, imem_req}, 64'h0);
    chk("midrst_valid", {63'h0, if_valid}, 64'h0);
    chk("midrst_addr",  {32'h0, imem_addr}, 64'h0);
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    chk("late_rsp_valid", {63'h0, if_valid}, 64'h0);
    chk("late_rsp_req",   {63'h0, imem_req}, 64'h1);
    chk("late_rsp_addr",  {32'h0, imem_addr}, 64'h0);

    // Scoreboard drained
    tick();
    chk("addr_q_empty", 64'(exp_addr_q.size()), 64'h0);
    chk("if_q_empty",   64'(exp_if_q.size()),   64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
